// File: rtl/ray_march_stepper.sv
// ray_march_stepper
// Marches a ray across the screen from a start pixel along a normalized
// fixed-point direction. It emits one sample point per accepted output beat.
// The march ends after steps+1 points, or sooner if a point falls off screen.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start_valid/start_ready  march request handshake
//   start_x, start_y         start pixel (unsigned integer)
//   dir_x, dir_y             per-step move, two's complement, FRAC fraction bits
//   steps                    number of steps (steps+1 points unless cut short)
//   out_valid/out_ready      sample point handshake
//   out_x, out_y             floor of the accumulated position, low 10 bits
//   out_last                 final point of this march
//   out_oob                  point lies outside 0..XMAX-1 / 0..YMAX-1
//   busy                     a march is in progress
module ray_march_stepper #(
  parameter int FRAC = 4,
  parameter int XMAX = 640,
  parameter int YMAX = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [9:0]        start_x,
  input  logic [9:0]        start_y,
  input  logic signed [10:0] dir_x,
  input  logic signed [10:0] dir_y,
  input  logic [7:0]        steps,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y,
  output logic              out_last,
  output logic              out_oob,
  output logic              busy
);

  // 16 bits is enough: each step moves at most 64 px, and the march stops
  // as soon as a point leaves the screen, so the value stays in -2048..2047.
  localparam int ACC_W = 16;
  localparam int IW    = ACC_W - FRAC;

  localparam logic signed [IW-1:0] XLIM = IW'(XMAX);
  localparam logic signed [IW-1:0] YLIM = IW'(YMAX);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc_x_p0, acc_y_p0;
  logic signed [10:0]       dir_x_p0, dir_y_p0;
  logic [7:0]               rem_p0;

  logic signed [IW-1:0]     fx, fy;
  logic                     oob_raw, last_raw;

  // An arithmetic shift gives floor(), so negative positions round toward -inf.
  function automatic logic signed [IW-1:0] floor_int(input logic signed [ACC_W-1:0] a);
    return IW'(a >>> FRAC);
  endfunction

  function automatic logic signed [ACC_W-1:0] load_int(input logic [9:0] p);
    return ACC_W'({p, {FRAC{1'b0}}});
  endfunction

  assign fx       = floor_int(acc_x_p0);
  assign fy       = floor_int(acc_y_p0);
  assign oob_raw  = (fx < 0) || (fx >= XLIM) || (fy < 0) || (fy >= YLIM);
  assign last_raw = (rem_p0 == '0) || oob_raw;

  // Flags are only meaningful while a point is presented.
  assign out_x    = fx[9:0];
  assign out_y    = fy[9:0];
  assign out_oob  = (state == EMIT) && oob_raw;
  assign out_last = (state == EMIT) && last_raw;

  // Stage p0: position accumulators and step control
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      acc_x_p0    <= '0;
      acc_y_p0    <= '0;
      dir_x_p0    <= '0;
      dir_y_p0    <= '0;
      rem_p0      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            acc_x_p0    <= load_int(start_x);
            acc_y_p0    <= load_int(start_y);
            dir_x_p0    <= dir_x;
            dir_y_p0    <= dir_y;
            rem_p0      <= steps;
            state       <= EMIT;
            start_ready <= 1'b0;
            out_valid   <= 1'b1;
            busy        <= 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last_raw) begin
              state       <= IDLE;
              start_ready <= 1'b1;
              out_valid   <= 1'b0;
              busy        <= 1'b0;
            end else begin
              acc_x_p0 <= acc_x_p0 + ACC_W'(dir_x_p0);
              acc_y_p0 <= acc_y_p0 + ACC_W'(dir_y_p0);
              rem_p0   <= rem_p0 - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_march_stepper.sv
module tb_ray_march_stepper;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_valid;
  logic              start_ready;
  logic [9:0]        start_x, start_y;
  logic signed [10:0] dir_x, dir_y;
  logic [7:0]        steps;
  logic              out_valid;
  logic              out_ready;
  logic [9:0]        out_x, out_y;
  logic              out_last, out_oob, busy;

  always #5 clk = ~clk;

  ray_march_stepper dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_x(start_x), .start_y(start_y),
    .dir_x(dir_x), .dir_y(dir_y), .steps(steps),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .out_oob(out_oob), .busy(busy)
  );

  typedef struct packed {
    logic [9:0]       sx, sy;
    logic [10:0]      dx, dy;
    logic [7:0]       st;
    logic [3:0]       n;
    logic [7:0][9:0]  ex, ey;
    logic [7:0]       eoob;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input int sx, input int sy, input int dx, input int dy, input int st);
    vecs[i]    = '0;
    vecs[i].sx = 10'(sx);
    vecs[i].sy = 10'(sy);
    vecs[i].dx = 11'(dx);
    vecs[i].dy = 11'(dy);
    vecs[i].st = 8'(st);
  endtask

  task automatic addp(input int i, input int x, input int y, input bit oob);
    int b;
    b = int'(vecs[i].n);
    vecs[i].ex[b]   = 10'(x);
    vecs[i].ey[b]   = 10'(y);
    vecs[i].eoob[b] = oob;
    vecs[i].n       = vecs[i].n + 4'd1;
  endtask

  task automatic check_pt(input string tag, input int x, input int y, input bit last, input bit oob);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " x"},     32'(out_x),     32'(x));
    chk({tag, " y"},     32'(out_y),     32'(y));
    chk({tag, " last"},  32'(out_last),  32'(last));
    chk({tag, " oob"},   32'(out_oob),   32'(oob));
  endtask

  task automatic request(input int sx, input int sy, input int dx, input int dy, input int st);
    @(negedge clk);
    chk("req start_ready", 32'(start_ready), 32'd1);
    start_x = 10'(sx); start_y = 10'(sy);
    dir_x = 11'(dx); dir_y = 11'(dy); steps = 8'(st);
    start_valid = 1'b1;
    @(negedge clk);
    // Scramble the request inputs: they must have been captured already.
    start_valid = 1'b0;
    start_x = 10'h3FF; start_y = 10'h155;
    dir_x = 11'h3AA; dir_y = 11'h555; steps = 8'hFF;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " idle valid"}, 32'(out_valid),   32'd0);
    chk({tag, " idle busy"},  32'(busy),        32'd0);
    chk({tag, " idle ready"}, 32'(start_ready), 32'd1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    out_ready = 1'b1;
    request(int'(v.sx), int'(v.sy), int'($signed(v.dx)), int'($signed(v.dy)), int'(v.st));
    for (int b = 0; b < int'(v.n); b++) begin
      check_pt($sformatf("v%0d b%0d", i, b), int'(v.ex[b]), int'(v.ey[b]),
               b == int'(v.n) - 1, v.eoob[b]);
      chk($sformatf("v%0d b%0d busy", i, b), 32'(busy), 32'd1);
      @(negedge clk);
    end
    check_idle($sformatf("v%0d", i));
  endtask

  initial begin
    // Table: request and hand-computed points (x, y, oob); last on final point.
    setv(0, 10, 20, 16, 0, 3);
    addp(0, 10, 20, 0); addp(0, 11, 20, 0); addp(0, 12, 20, 0); addp(0, 13, 20, 0);
    setv(1, 1, 0, -8, 8, 4);
    addp(1, 1, 0, 0); addp(1, 0, 0, 0); addp(1, 0, 1, 0); addp(1, 1023, 1, 1);
    setv(2, 5, 5, 16, 16, 0);
    addp(2, 5, 5, 0);
    setv(3, 700, 0, 16, 0, 5);
    addp(3, 700, 0, 1);
    setv(4, 0, 0, 0, 0, 2);
    addp(4, 0, 0, 0); addp(4, 0, 0, 0); addp(4, 0, 0, 0);
    setv(5, 639, 479, -16, -16, 2);
    addp(5, 639, 479, 0); addp(5, 638, 478, 0); addp(5, 637, 477, 0);
    setv(6, 638, 100, 16, 0, 3);
    addp(6, 638, 100, 0); addp(6, 639, 100, 0); addp(6, 640, 100, 1);
    setv(7, 3, 478, 0, 16, 5);
    addp(7, 3, 478, 0); addp(7, 3, 479, 0); addp(7, 3, 480, 1);
    setv(8, 2, 2, 24, -4, 3);
    addp(8, 2, 2, 0); addp(8, 3, 1, 0); addp(8, 5, 1, 0); addp(8, 6, 1, 0);

    rst = 1'b1; start_valid = 1'b0; out_ready = 1'b1;
    start_x = '0; start_y = '0; dir_x = '0; dir_y = '0; steps = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset x",    32'(out_x),    32'd0);
    chk("reset y",    32'(out_y),    32'd0);
    chk("reset last", 32'(out_last), 32'd0);
    chk("reset oob",  32'(out_oob),  32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure on the 2nd point plus a request while busy.
    out_ready = 1'b1;
    request(10, 20, 16, 0, 3);
    check_pt("bp b0", 10, 20, 0, 0);
    @(negedge clk);
    out_ready = 1'b0;
    start_valid = 1'b1; start_x = 10'd100; start_y = 10'd100;
    dir_x = 11'sd16; dir_y = 11'sd16; steps = 8'd0;
    for (int c = 0; c < 5; c++) begin
      check_pt($sformatf("bp hold%0d", c), 11, 20, 0, 0);
      chk($sformatf("bp hold%0d start_ready", c), 32'(start_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; start_valid = 1'b0;
    check_pt("bp b1", 11, 20, 0, 0);
    @(negedge clk);
    check_pt("bp b2", 12, 20, 0, 0);
    @(negedge clk);
    check_pt("bp b3", 13, 20, 1, 0);
    @(negedge clk);
    check_idle("bp");
    @(negedge clk);
    chk("bp no stray march", 32'(out_valid), 32'd0);

    // Reset after the 3rd point of a long march.
    request(50, 60, 16, 16, 10);
    check_pt("rst b0", 50, 60, 0, 0);
    @(negedge clk);
    check_pt("rst b1", 51, 61, 0, 0);
    @(negedge clk);
    check_pt("rst b2", 52, 62, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst");
    chk("rst x", 32'(out_x), 32'd0);
    chk("rst y", 32'(out_y), 32'd0);
    @(negedge clk);
    chk("rst stays idle", 32'(out_valid), 32'd0);
    run_vec(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
